// File: rtl/shifter_pkg.sv
// Shared encodings, command struct and the combinational command normaliser
// for the 16/32-bit multifunction shifter.
package shifter_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    localparam logic [1:0] OP_ROL = 2'd0;
    localparam logic [1:0] OP_ROR = 2'd1;
    localparam logic [1:0] OP_SLL = 2'd2;
    localparam logic [1:0] OP_SRA = 2'd3;

    localparam logic W16 = 1'b0;
    localparam logic W32 = 1'b1;

    typedef struct packed {
        logic [1:0]        op;
        logic              width;
        logic [AMT_W-1:0]  amt;
        logic [DATA_W-1:0] data;
        logic              fill;
    } cmd_t;

    // Rotates become left-rotates, so the datapath only needs one rotate direction.
    function automatic cmd_t normalise(input logic [1:0]        op,
                                       input logic              width,
                                       input logic [AMT_W-1:0]  amt,
                                       input logic [DATA_W-1:0] data);
        cmd_t             c;
        logic [AMT_W-1:0] m;
        m = amt;
        if (width == W16) m[AMT_W-1] = 1'b0;
        c.op    = op;
        c.width = width;
        c.amt   = m;
        c.data  = data;
        c.fill  = 1'b0;
        if (width == W16) c.data[DATA_W-1:DATA_W/2] = '0;
        if (op == OP_ROR) begin
            c.op  = OP_ROL;
            c.amt = (~m) + 1'b1;
            if (width == W16) c.amt[AMT_W-1] = 1'b0;
        end
        if (op == OP_SRA)
            c.fill = (width == W32) ? data[DATA_W-1] : data[DATA_W/2-1];
        return c;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: main output register plus one skid slot.
// in_ready is simply "skid slot empty", so it is a pure register output.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         s_valid;
    logic [W-1:0] s_data;
    logic         acc;

    assign in_ready = ~s_valid;
    assign acc      = in_valid & ~s_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            s_valid   <= 1'b0;
            s_data    <= '0;
        end else if (s_valid) begin
            // skid full implies main full; drain skid into main on consume
            if (out_ready) begin
                out_data <= s_data;
                s_valid  <= 1'b0;
            end
        end else if (!out_valid || out_ready) begin
            out_valid <= acc;
            if (acc) out_data <= in_data;
        end else if (acc) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
        end
    end

endmodule

// File: rtl/shift_cmd_stage.sv
// Command-normalisation stage ahead of the rotate/shift datapath: normalises
// each accepted command and presents it through a 2-entry skid buffer.
module shift_cmd_stage #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_width,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_op,
    output logic              out_width,
    output logic [AMT_W-1:0]  out_amt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_fill,
    output logic [CNT_W-1:0]  cmd_count
);
    import shifter_pkg::*;

    cmd_t n_cmd;
    cmd_t o_cmd;

    assign n_cmd = normalise(in_op, in_width, in_amt, in_data);

    skid_buffer #(.W($bits(cmd_t))) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (n_cmd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (o_cmd)
    );

    assign out_op    = o_cmd.op;
    assign out_width = o_cmd.width;
    assign out_amt   = o_cmd.amt;
    assign out_data  = o_cmd.data;
    assign out_fill  = o_cmd.fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cmd_count <= '0;
        else if (out_valid && out_ready) cmd_count <= cmd_count + 1'b1;
    end

endmodule

// File: tb/tb_shift_cmd_stage.sv
// Directed self-checking bench for shift_cmd_stage.
module tb_shift_cmd_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_width;
    logic [4:0]  in_amt;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_op;
    logic        out_width;
    logic [4:0]  out_amt;
    logic [31:0] out_data;
    logic        out_fill;
    logic [15:0] cmd_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    shift_cmd_stage #(.DATA_W(32), .AMT_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_width(in_width), .in_amt(in_amt), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_width(out_width), .out_amt(out_amt),
        .out_data(out_data), .out_fill(out_fill), .cmd_count(cmd_count)
    );

    // Present one command for exactly one edge with out_ready low.
    task automatic issue(input logic [1:0] op, input logic w, input logic [4:0] amt,
                         input logic [31:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_width = w; in_amt = amt; in_data = d;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'd0; in_width = 1'b0; in_amt = 5'd0; in_data = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_op, out_width, out_amt, out_data, out_fill, cmd_count} !==
            {1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'd0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b amt=%0d data=%h cnt=%0d required 0/1/0/0/0",
                     out_valid, in_ready, out_amt, out_data, cmd_count);
        end
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_ror16();
        issue(2'd1, 1'b0, 5'd4, 32'h0000_1234);
        checks++;
        if ({out_valid, out_op, out_width, out_amt, out_data, out_fill} !==
            {1'b1, 2'd0, 1'b0, 5'd12, 32'h0000_1234, 1'b0}) begin
            errors++;
            $display("FAIL ror16: v=%b op=%0d amt=%0d data=%h fill=%b required 1/0/12/00001234/0",
                     out_valid, out_op, out_amt, out_data, out_fill);
        end
        consume();
        checks++;
        if (cmd_count !== 16'(exp_cnt) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ror16_count: cnt=%0d v=%b required %0d/0", cmd_count, out_valid, exp_cnt);
        end
    endtask

    task automatic test_ror32();
        issue(2'd1, 1'b1, 5'd1, 32'hDEAD_BEEF);
        checks++;
        if ({out_op, out_width, out_amt, out_data} !== {2'd0, 1'b1, 5'd31, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL ror32_amt1: op=%0d amt=%0d data=%h required 0/31/deadbeef", out_op, out_amt, out_data);
        end
        consume();
        issue(2'd1, 1'b1, 5'd0, 32'h8000_0000);
        checks++;
        if ({out_op, out_amt, out_fill} !== {2'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL ror32_amt0: op=%0d amt=%0d fill=%b required 0/0/0", out_op, out_amt, out_fill);
        end
        consume();
        checks++;
        if (cmd_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL ror32_count: cnt=%0d required %0d", cmd_count, exp_cnt);
        end
    endtask

    task automatic test_sra16();
        issue(2'd3, 1'b0, 5'h11, 32'hABCD_8001);
        checks++;
        if ({out_op, out_width, out_amt, out_data, out_fill} !==
            {2'd3, 1'b0, 5'd1, 32'h0000_8001, 1'b1}) begin
            errors++;
            $display("FAIL sra16: op=%0d amt=%0d data=%h fill=%b required 3/1/00008001/1",
                     out_op, out_amt, out_data, out_fill);
        end
        consume();
        // SLL never produces a fill bit even with the sign bit set
        issue(2'd2, 1'b1, 5'd20, 32'hF000_0000);
        checks++;
        if ({out_op, out_amt, out_fill} !== {2'd2, 5'd20, 1'b0}) begin
            errors++;
            $display("FAIL sll32: op=%0d amt=%0d fill=%b required 2/20/0", out_op, out_amt, out_fill);
        end
        consume();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'd0; in_width = 1'b1; in_amt = 5'd3; in_data = 32'h1111_1111;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: in_ready=%b v=%b required 1/1", in_ready, out_valid);
        end
        in_op = 2'd2; in_amt = 5'd7; in_data = 32'h2222_2222;
        @(negedge clk);
        in_op = 2'd1; in_width = 1'b0; in_amt = 5'd5; in_data = 32'h3333_3333;
        checks++;
        if (in_ready !== 1'b0 || out_amt !== 5'd3 || out_data !== 32'h1111_1111) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b amt=%0d data=%h required 0/3/11111111", in_ready, out_amt, out_data);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op !== 2'd0 || out_amt !== 5'd3 ||
            out_data !== 32'h1111_1111) begin
            errors++;
            $display("FAIL bp_stable: in_ready=%b v=%b op=%0d amt=%0d data=%h required 0/1/0/3/11111111",
                     in_ready, out_valid, out_op, out_amt, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_op !== 2'd2 || out_amt !== 5'd7 || out_data !== 32'h2222_2222) begin
            errors++;
            $display("FAIL bp_drain: in_ready=%b op=%0d amt=%0d data=%h required 1/2/7/22222222",
                     in_ready, out_op, out_amt, out_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_op !== 2'd0 || out_amt !== 5'd11 || out_data !== 32'h0000_3333) begin
            errors++;
            $display("FAIL bp_third: v=%b op=%0d amt=%0d data=%h required 1/0/11/00003333",
                     out_valid, out_op, out_amt, out_data);
        end
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt += 3;
        checks++;
        if (out_valid !== 1'b0 || cmd_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL bp_count: v=%b cnt=%0d required 0/%0d", out_valid, cmd_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'd3; in_width = 1'b1; in_amt = 5'd9; in_data = 32'h8765_4321;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_fill: in_ready=%b v=%b required 0/1", in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cmd_count !== 16'd0 || out_amt !== 5'd0 ||
            out_data !== 32'd0 || out_fill !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: v=%b in_ready=%b cnt=%0d amt=%0d data=%h fill=%b required 0/1/0/0/0/0",
                     out_valid, in_ready, cmd_count, out_amt, out_data, out_fill);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        out_ready = 1'b0;
        checks++;
        if (stale != 0 || cmd_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_stale: stale_cycles=%0d cnt=%0d required 0/0", stale, cmd_count);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int first_bad = -1;
        @(negedge clk);
        out_ready = 1'b1;
        in_op = 2'd0; in_width = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_valid = 1'b1;
            in_amt  = 5'(i);
            in_data = 32'(i);
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_amt !== 5'(i) || out_data !== 32'(i)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        exp_cnt = (exp_cnt + 70000) % 65536;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stream: bad_cycles=%0d first_at=%0d required 0", bad, first_bad);
        end
        checks++;
        if (cmd_count !== 16'(exp_cnt) || cmd_count !== 16'd4464 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_count: cnt=%0d v=%b required 4464/0", cmd_count, out_valid);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ror16();
        test_ror32();
        test_sra16();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_cmd_stage.md
# shift_cmd_stage

Registered command-normalisation stage that sits directly upstream of the rotate/shift datapath in the 16/32-bit multifunction shifter. It accepts shift commands over a valid/ready handshake and masks data to the selected width. It converts every rotate into a left-rotate amount and derives the fill bit for arithmetic shifts. It then presents one normalised command per cycle to the combinational shifter through a 2-entry skid buffer, giving full throughput under backpressure.

## Interface
Parameters:
- DATA_W, 32: maximum operand width; the 16-bit mode uses the low half.
- AMT_W, 5: amount field width, equal to log2(DATA_W).
- CNT_W, 16: width of the completed-command counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  stage can accept a command.
- in_op  in  2  operation: 0 ROL, 1 ROR, 2 SLL, 3 SRA.
- in_width  in  1  operand width: 0 is 16-bit, 1 is 32-bit.
- in_amt  in  AMT_W  raw shift/rotate amount.
- in_data  in  DATA_W  operand.
- out_valid  out  1  normalised command present.
- out_ready  in  1  downstream consumes the command.
- out_op  out  2  op passed through, except that ROR is reported as ROL.
- out_width  out  1  width passed through.
- out_amt  out  AMT_W  normalised amount.
- out_data  out  DATA_W  width-masked operand.
- out_fill  out  1  fill bit for SRA, otherwise 0.
- cmd_count  out  CNT_W  number of completed output handshakes.

## Operation
- Accept: a command is taken when in_valid and in_ready are both high on a rising edge.
- Width masking: when in_width is 0, out_data[31:16] = 0, and in_amt[4] is ignored (amount taken mod 16). When in_width is 1, the amount is taken mod 32.
- ROL: out_amt = amt mod W.
- ROR: out_amt = (W − (amt mod W)) mod W, and out_op = 0 (ROL). ROR by 0 therefore yields out_amt 0.
- SLL and SRA: out_amt = amt mod W; out_op is passed through unchanged.
- out_fill: for SRA it equals in_data[15] when in_width is 0, and in_data[31] when in_width is 1. It is 0 for every other op.
- Skid buffer: a main register plus one skid register.
  - When out_ready is low and the main register is occupied, a newly accepted command goes to the skid register.
  - in_ready is registered and equals "skid register empty".
  - Order is strictly FIFO; no command is ever dropped or duplicated.
- Counter: cmd_count increments on each out_valid && out_ready. It wraps from 2^CNT_W − 1 to 0.

## Timing
- Reset values: out_valid 0, in_ready 1, out_op/out_width/out_amt/out_data/out_fill all 0, cmd_count 0. Both buffer entries are empty.
- Latency: 1 cycle. A command accepted at edge N appears on out_valid/out_* after edge N when the buffer was empty.
- Throughput: 1 command per cycle while out_ready stays high.
- Stability: while out_valid is high and out_ready is low, all out_* signals hold their values.
- Backpressure: one further accept is possible after out_ready drops; in_ready then falls on the next edge.
- Skid drain: when out_ready rises with both entries full, the skid entry moves to main on that edge, and in_ready rises on the same edge.
- Simultaneous accept and consume with one entry full: the new command replaces main; the skid register stays empty.
- Reset asserted mid-operation: all buffered commands are discarded immediately (asynchronously), and outputs take their reset values.

## Structure
- Shared package shifter_pkg holds:
  - the op encoding constants (OP_ROL, OP_ROR, OP_SLL, OP_SRA);
  - the width encoding constants (W16, W32);
  - DATA_W and AMT_W defaults;
  - a packed command struct {op, width, amt, data, fill}.
- Normalisation is a combinational function in shifter_pkg, applied before the buffer.
- Sub-module skid_buffer, parameterised by payload width, holds the two-entry handshake logic. shift_cmd_stage instantiates it once.

## Test plan
- Reset, then a ROR command with width 16, amt 4, data 0x0000_1234 → one cycle later: out_op 0, out_amt 12, out_data 0x0000_1234, out_fill 0; cmd_count becomes 1 after the consume.
- ROR with width 32, amt 1 → out_amt 31. ROR with width 32, amt 0 → out_amt 0.
- SRA with width 16, amt 17 (0x11), data 0xABCD_8001 → out_amt 1, out_data 0x0000_8001, out_fill 1.
- Hold out_ready low and offer 3 back-to-back commands → exactly 2 accepted, in_ready low, out_* stable. Raise out_ready → the commands emerge in order and the third is accepted.
- Stream 70000 commands with out_ready always high → one out_valid per cycle after the first; cmd_count reads 70000 mod 65536 = 4464.
- Assert rst_n low with both buffer entries full → out_valid 0 and in_ready 1 immediately. After release, no stale command is emitted.
